// File: rtl/constants_pkg.sv
// Shared architectural widths for the pipeline stages.
package constants_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
endpackage

// File: rtl/if_id_buffer.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO of {pc, instr} pairs.
// Outputs come only from registered state. Nothing passes straight from the inputs to the outputs.
//
// Handshakes (valid/ready):
//   fetch side : a beat transfers on a rising edge where valid_i=1 and stall_o=0.
//                stall_o is the inverse of ready. Fetch must hold the instruction until it is taken.
//   decode side: a beat transfers on a rising edge where valid_o=1 and ready_i=1.
//                ready_i is ignored while valid_o=0.
//   flush_i and rst cancel both transfers for that edge. rst takes priority over flush_i.
module if_id_buffer
  import constants_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ILEN-1:0]          instr_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic                     valid_i,
  output logic                     stall_o,
  input  logic                     flush_i,
  output logic [ILEN-1:0]          instr_o,
  output logic [XLEN-1:0]          pc_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  logic [ILEN-1:0] mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic            enq;
  logic            deq;

  assign stall_o = (count == CW'(DEPTH));
  assign valid_o = (count != '0);
  assign count_o = count;

  assign enq = valid_i && !stall_o;
  assign deq = valid_o && ready_i;

  assign instr_o = valid_o ? mem_instr[head] : NOP;
  assign pc_o    = valid_o ? mem_pc[head]    : '0;

  // The pointers are AW bits wide and DEPTH is a power of two, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Reset and flush leave the entry contents alone. Only the pointers and count are visible.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && enq) begin
      mem_instr[tail] <= instr_i;
      mem_pc[tail]    <= pc_i;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed tests for if_id_buffer: reset, fill, drain order, concurrent traffic with pointer wrap, flush, reset priority and empty reads.
`timescale 1ns/1ps
module tb_if_id_buffer;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        valid_i;
  logic        stall_o;
  logic        flush_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  count_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  if_id_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instr_i(instr_i), .pc_i(pc_i), .valid_i(valid_i),
    .stall_o(stall_o), .flush_i(flush_i), .instr_o(instr_o), .pc_o(pc_o),
    .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  // driver tasks: set the inputs, take one edge, then settle just after it
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic fl, input logic r);
    valid_i = v;
    pc_i    = pc;
    instr_i = instr_of(pc);
    ready_i = rdy;
    flush_i = fl;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; rst = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle_inputs();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_o); end
    checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h exp 00000013", instr_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc_o); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'(4 * i));
      checks++; if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count_o, i + 1); end
      checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL fill_head got %h exp 0", pc_o); end
    end
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL fill_stall got %b exp 1", stall_o); end
    drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_overflow_count got %0d exp 4", count_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL fill_overflow_head got %h exp 0", pc_o); end
    idle_inputs();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b0; ready_i = 1'b1; #1;
      checks++; if (pc_o !== exp_q[0]) begin errors++; $display("FAIL drain_pc got %h exp %h", pc_o, exp_q[0]); end
      checks++; if (instr_o !== instr_of(exp_q[0])) begin errors++; $display("FAIL drain_instr got %h exp %h", instr_o, instr_of(exp_q[0])); end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", valid_o); end
    checks++; if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL drain_nop got %h exp 00000013", instr_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count_o); end
    idle_inputs();
  endtask

  task automatic test_concurrent();
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0); exp_q.push_back(32'h100);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0); exp_q.push_back(32'h104);
    for (int i = 0; i < 6; i++) begin
      checks++; if (pc_o !== exp_q[0]) begin errors++; $display("FAIL conc_head got %h exp %h", pc_o, exp_q[0]); end
      drive(1'b1, 32'(32'h108 + 4 * i), 1'b1, 1'b0, 1'b0);
      void'(exp_q.pop_front());
      exp_q.push_back(32'(32'h108 + 4 * i));
      checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL conc_count got %0d exp 2", count_o); end
    end
    for (int i = 0; i < 2; i++) begin
      checks++; if (pc_o !== exp_q[0]) begin errors++; $display("FAIL conc_tail_pc got %h exp %h", pc_o, exp_q[0]); end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL conc_empty got %b exp 0", valid_o); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'(32'h200 + 4 * i), 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d exp 3", count_o); end
    drive(1'b1, 32'h20C, 1'b1, 1'b1, 1'b0);
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", valid_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall_o); end
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    checks++; if (pc_o !== 32'h300) begin errors++; $display("FAIL flush_reuse_pc got %h exp 00000300", pc_o); end
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL flush_reuse_count got %0d exp 1", count_o); end
    idle_inputs();
  endtask

  task automatic test_reset_priority();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'(32'h400 + 4 * i), 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL rprio_pre_count got %0d exp 4", count_o); end
    drive(1'b1, 32'h410, 1'b1, 1'b1, 1'b1);
    idle_inputs();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL rprio_count got %0d exp 0", count_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rprio_pc got %h exp 0", pc_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rprio_valid got %b exp 0", valid_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rprio_stall got %b exp 0", stall_o); end
  endtask

  task automatic test_empty_read();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL empty_count got %0d exp 0", count_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL empty_valid got %b exp 0", valid_o); end
    end
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL empty_then_enq got %0d exp 1", count_o); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    pc_i = '0; instr_i = '0; rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_drain();
    test_concurrent();
    test_flush();
    test_reset_priority();
    test_empty_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
